// File: rtl/fc_neuron_accumulator_pkg.sv
// Shared FC-stage definitions: FSM state encoding, default operand widths,
// and the accumulator-width helper used by the neuron accumulator and scaler.
package fc_neuron_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  localparam int DEF_N    = 5;
  localparam int DEF_FRAC = 2;

  // Wide enough that NUM_INPUTS products plus a bias can never overflow.
  function automatic int acc_width(input int n, input int num_inputs);
    return 2 * n + $clog2(num_inputs) + 1;
  endfunction

endpackage

// File: rtl/fc_neuron_accumulator_sat_scale.sv
// Combinational rescale of a signed ACCW-bit sum: floor shift by FRAC,
// optional ReLU, then saturation to a signed N-bit activation.
module fc_neuron_accumulator_sat_scale #(
  parameter int N    = 5,
  parameter int ACCW = 13,
  parameter int FRAC = 2,
  parameter int RELU = 1
) (
  input  logic [ACCW-1:0] i_sum,
  output logic [N-1:0]    o_act
);

  localparam logic signed [ACCW-1:0] W_MAX = ACCW'((2 ** (N - 1)) - 1);
  localparam logic signed [ACCW-1:0] W_MIN = ACCW'(-(2 ** (N - 1)));

  logic signed [ACCW-1:0] w_shift;
  logic signed [ACCW-1:0] w_relu;

  always_comb begin
    w_shift = $signed(i_sum) >>> FRAC;
    w_relu  = w_shift;
    if ((RELU != 0) && (w_shift < 0)) begin
      w_relu = '0;
    end
    if (w_relu > W_MAX) begin
      o_act = W_MAX[N-1:0];
    end else if (w_relu < W_MIN) begin
      o_act = W_MIN[N-1:0];
    end else begin
      o_act = w_relu[N-1:0];
    end
  end

endmodule

// File: rtl/fc_neuron_accumulator.sv
// FC neuron: accumulates NUM_INPUTS signed products onto a bias, then emits a
// scaled/ReLU'd/saturated N-bit activation with ready/valid on both sides.
module fc_neuron_accumulator
  import fc_neuron_accumulator_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int NUM_INPUTS = 16,
  parameter int FRAC       = DEF_FRAC,
  parameter int RELU       = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [2*N-1:0] i_bias,
  input  logic [2*N-1:0] i_prod,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  output logic [N-1:0]   o_out_data,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic           o_busy
);

  localparam int ACCW = acc_width(N, NUM_INPUTS);
  localparam int CNTW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NUM_INPUTS - 1);

  state_e          r_state;
  logic [ACCW-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;
  logic [N-1:0]    r_out_data;
  logic            r_out_valid;

  logic            w_accept;
  logic [ACCW-1:0] w_prod_ext;
  logic [ACCW-1:0] w_bias_ext;
  logic [ACCW-1:0] w_sum_next;
  logic [N-1:0]    w_act;

  assign o_in_ready  = (r_state == ST_ACCUM);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;

  assign w_accept   = i_in_valid && o_in_ready;
  assign w_prod_ext = {{(ACCW - 2*N){i_prod[2*N-1]}}, i_prod};
  assign w_bias_ext = {{(ACCW - 2*N){i_bias[2*N-1]}}, i_bias};
  assign w_sum_next = r_acc + w_prod_ext;

  // Scaling sees the sum including the product being accepted, so the
  // result registers on the same edge as the final accept.
  fc_neuron_accumulator_sat_scale #(
    .N    (N),
    .ACCW (ACCW),
    .FRAC (FRAC),
    .RELU (RELU)
  ) u_sat_scale (
    .i_sum (w_sum_next),
    .o_act (w_act)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc   <= w_bias_ext;
            r_cnt   <= '0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_out_data  <= w_act;
              r_out_valid <= 1'b1;
              r_state     <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_neuron_accumulator.sv
// Bench for fc_neuron_accumulator: RELU=1 and RELU=0 instances share stimulus;
// expected activations are queued at issue time and popped on each handshake.
module tb_fc_neuron_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] bias = '0;
  logic [9:0] prod = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       rdy1, vld1, busy1;
  logic [4:0] dat1;
  logic       rdy0, vld0, busy0;
  logic [4:0] dat0;

  int n_tests = 0;
  int n_fail  = 0;
  int q1[$];
  int q0[$];

  always #5 clk = ~clk;

  fc_neuron_accumulator #(.N(5), .NUM_INPUTS(4), .FRAC(2), .RELU(1)) u_dut_relu (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bias(bias), .i_prod(prod),
    .i_in_valid(in_valid), .o_in_ready(rdy1), .o_out_data(dat1),
    .o_out_valid(vld1), .i_out_ready(out_ready), .o_busy(busy1)
  );

  fc_neuron_accumulator #(.N(5), .NUM_INPUTS(4), .FRAC(2), .RELU(0)) u_dut_lin (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bias(bias), .i_prod(prod),
    .i_in_valid(in_valid), .o_in_ready(rdy0), .o_out_data(dat0),
    .o_out_valid(vld0), .i_out_ready(out_ready), .o_busy(busy0)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic int model(input int s, input bit relu);
    int r;
    r = s >>> 2;
    if (relu && r < 0) r = 0;
    if (r > 15) r = 15;
    if (r < -16) r = -16;
    return r;
  endfunction

  // Monitor: a handshake is pending whenever valid && ready is seen mid-cycle.
  always @(negedge clk) begin
    if (!rst && vld1 && out_ready) begin
      chk("lockstep_valid", int'(vld0), 1);
      if (q1.size() == 0 || q0.size() == 0) begin
        note_fail("unexpected_output");
      end else begin
        chk("out_relu1", int'($signed(dat1)), q1.pop_front());
        chk("out_relu0", int'($signed(dat0)), q0.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_neuron(input int b);
    start = 1'b1;
    bias  = 10'(b);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int p);
    int g;
    g = 0;
    prod     = 10'(p);
    in_valid = 1'b1;
    while (!rdy1 && g < 50) begin
      tick();
      g++;
    end
    if (!rdy1) note_fail("feed_timeout");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy1 && g < 200) begin
      tick();
      g++;
    end
    if (busy1) note_fail("idle_timeout");
  endtask

  task automatic push(input int e1, input int e0);
    q1.push_back(e1);
    q0.push_back(e0);
  endtask

  initial begin
    int v_pat[6];
    int p_pat[6];
    v_pat = '{1, 0, 1, 0, 1, 1};
    p_pat = '{8, 100, 12, 100, -4, 16};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", int'(rdy1), 0);
    chk("rst_out_valid", int'(vld1), 0);
    chk("rst_out_data", int'(dat1), 0);
    chk("rst_busy", int'(busy1), 0);

    // Basic: 24 >>> 2 = 6
    out_ready = 1'b1;
    push(6, 6);
    start_neuron(0);
    chk("accum_busy", int'(busy1), 1);
    chk("accum_in_ready", int'(rdy1), 1);
    feed(6); feed(6); feed(6);
    chk("no_early_valid", int'(vld1), 0);
    feed(6);
    chk("latency_valid", int'(vld1), 1);
    chk("output_in_ready", int'(rdy1), 0);
    tick();
    chk("idle_after_hs", int'(busy1), 0);

    // Saturation and sign
    push(15, 15);
    start_neuron(0);
    for (int i = 0; i < 4; i++) feed(100);
    wait_idle();
    push(0, -16);
    start_neuron(-4);
    for (int i = 0; i < 4; i++) feed(-20);
    wait_idle();

    // Bias and floor: S=2 -> 0, S=-3 -> -1 (or 0 with ReLU)
    push(0, 0);
    start_neuron(3);
    feed(-1); feed(0); feed(0); feed(0);
    wait_idle();
    push(0, -1);
    start_neuron(-3);
    for (int i = 0; i < 4; i++) feed(0);
    wait_idle();

    // Input gaps and output backpressure: 8+12-4+16 = 32 -> 8
    out_ready = 1'b0;
    push(8, 8);
    start_neuron(0);
    for (int i = 0; i < 6; i++) begin
      in_valid = v_pat[i][0];
      prod     = 10'(p_pat[i]);
      tick();
    end
    in_valid = 1'b0;
    chk("four_accepts_valid", int'(vld1), 1);
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", int'(vld1), 1);
      chk("stall_data", int'($signed(dat1)), 8);
      chk("stall_in_ready", int'(rdy1), 0);
      start = (k == 1);
      bias  = 10'(7);
      tick();
      start = 1'b0;
    end
    chk("stall_busy", int'(busy1), 1);
    out_ready = 1'b1;
    tick();
    chk("hs_valid_drop", int'(vld1), 0);
    chk("hs_idle", int'(busy1), 0);

    // Reset mid-accumulation
    start_neuron(0);
    feed(50); feed(50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_valid", int'(vld1), 0);
    chk("midrst_in_ready", int'(rdy1), 0);
    push(4, 4);
    start_neuron(0);
    for (int i = 0; i < 4; i++) feed(4);
    wait_idle();

    // Random neurons with random valid/ready gaps
    for (int n = 0; n < 500; n++) begin
      int b, s, cnt, g, p;
      b = int'($urandom_range(0, 1023)) - 512;
      s = b;
      cnt = 0;
      g = 0;
      out_ready = 1'($urandom_range(0, 1));
      start_neuron(b);
      while (cnt < 4 && g < 100) begin
        p = int'($urandom_range(0, 1023)) - 512;
        prod      = 10'(p);
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        if (in_valid && rdy1) begin
          s += p;
          cnt++;
          if (cnt == 4) push(model(s, 1'b1), model(s, 1'b0));
        end
        tick();
        g++;
      end
      in_valid = 1'b0;
      if (cnt < 4) note_fail("random_accept_timeout");
      g = 0;
      while (busy1 && g < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        g++;
      end
      if (busy1) note_fail("random_output_timeout");
    end

    tick();
    chk("queue1_drained", q1.size(), 0);
    chk("queue0_drained", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
